// File: rtl/chan_share_arbiter.sv
// Round-robin arbiter sharing one word-wide clock-domain-crossing channel among N requesters.
// Optional feature macro: CHAN_TIMEOUT_EN (aborts OFFER/DRAIN after TO_CYCLES cycles).
module chan_share_arbiter #(
   parameter int unsigned N         = 4,
   parameter int unsigned W         = 8,
   parameter int unsigned SW        = $clog2(N),
   parameter int unsigned TO_CYCLES = 1023
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] req_data,
   output logic [N-1:0]   grant,
   output logic [W-1:0]   chan_data,
   output logic [SW-1:0]  chan_src,
   output logic           chan_valid,
   input  logic           chan_ready,
   output logic           busy,
   output logic           err_timeout
);

   typedef enum logic [1:0] {StIdle, StOffer, StDrain} state_e;

   if (N < 2 || N > 16 || TO_CYCLES == 0) begin : g_param_check
      $error("chan_share_arbiter: N must be 2..16 and TO_CYCLES nonzero");
   end

   state_e        state_q, state_d;
   logic [SW-1:0] last_q, last_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [W-1:0]  data_q, data_d;
   logic [SW-1:0] src_q, src_d;
   logic          valid_q, valid_d;

   logic          pick_found;
   logic [SW-1:0] pick_idx;
   logic [N-1:0]  pick_oh;
   logic [W-1:0]  pick_data;
   logic [31:0]   last_ext;

`ifdef CHAN_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TO_CYCLES + 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            to_hit;

   assign to_hit = (cnt_q == CntW'(TO_CYCLES - 1));
`endif

   assign last_ext = 32'(last_q);

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_oh    = '0;
      pick_data  = '0;
      // Two passes form a rotating priority: indices above last first, then wrap to 0..last.
      for (int unsigned i = 0; i < N; i++) begin
         if (!pick_found && req[i] && (i > last_ext)) begin
            pick_found = 1'b1;
            pick_idx   = SW'(i);
            pick_oh[i] = 1'b1;
            pick_data  = req_data[i*W +: W];
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (!pick_found && req[i] && (i <= last_ext)) begin
            pick_found = 1'b1;
            pick_idx   = SW'(i);
            pick_oh[i] = 1'b1;
            pick_data  = req_data[i*W +: W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      grant_d = '0;
      data_d  = data_q;
      src_d   = src_q;
      valid_d = valid_q;
`ifdef CHAN_TIMEOUT_EN
      cnt_d   = cnt_q + 1'b1;
      err_d   = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
`ifdef CHAN_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (chan_ready && pick_found) begin
               data_d  = pick_data;
               src_d   = pick_idx;
               last_d  = pick_idx;
               grant_d = pick_oh;
               valid_d = 1'b1;
               state_d = StOffer;
            end
         end
         StOffer: begin
            // Ready falling means the crossing has captured the word.
            if (!chan_ready) begin
               valid_d = 1'b0;
               state_d = StDrain;
`ifdef CHAN_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
`ifdef CHAN_TIMEOUT_EN
            else if (to_hit) begin
               valid_d = 1'b0;
               err_d   = 1'b1;
               state_d = StIdle;
               cnt_d   = '0;
            end
`endif
         end
         StDrain: begin
            if (chan_ready) begin
               state_d = StIdle;
            end
`ifdef CHAN_TIMEOUT_EN
            else if (to_hit) begin
               err_d   = 1'b1;
               state_d = StIdle;
               cnt_d   = '0;
            end
`endif
         end
         default: begin
            valid_d = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         last_q  <= SW'(N - 1);
         grant_q <= '0;
         data_q  <= '0;
         src_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         src_q   <= src_d;
         valid_q <= valid_d;
      end
   end

`ifdef CHAN_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_timeout = err_q;
`else
   assign err_timeout = 1'b0;
`endif

   assign grant      = grant_q;
   assign chan_data  = data_q;
   assign chan_src   = src_q;
   assign chan_valid = valid_q;
   assign busy       = (state_q != StIdle);

endmodule
